// File: rtl/spi_accel_slave.sv
// SPI mode-3 responder emulating a three-axis accelerometer with a 64x8 register file.
// Optional macro SPI_ACCEL_SLAVE_TXN_CNT_EN adds txn_count and cmd_err outputs.
module spi_accel_slave #(
  parameter logic [7:0]  DEVID_VAL   = 8'hE5,
  parameter logic [7:0]  BW_RATE_RST = 8'h0A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        CS,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_oe,
  input  logic [15:0] axis_x,
  input  logic [15:0] axis_y,
  input  logic [15:0] axis_z,
  input  logic        sample_valid,
  output logic        reg_wr_strobe,
  output logic [5:0]  reg_wr_addr,
  output logic [7:0]  reg_wr_data,
  output logic        busy
`ifdef SPI_ACCEL_SLAVE_TXN_CNT_EN
  ,
  output logic [15:0] txn_count,
  output logic        cmd_err
`endif
);

  typedef enum logic [1:0] {StIdle, StCmd, StRd, StWr} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, sdi_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_s, cs_s, sdi_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic [5:0] addr_q, addr_d;
  logic       mb_q, mb_d;
  logic       sdo_q, sdo_d;
  logic [7:0] rx_byte;
  logic [5:0] addr_inc, rd_addr;
  logic [7:0] rd_data;
  logic       byte_end, mem_we, ro_hit;

  logic [7:0]  mem_q [64];
  logic        wr_req_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;
  logic        pend_q;
  logic [15:0] pend_x_q, pend_y_q, pend_z_q;
  logic [15:0] ld_x, ld_y, ld_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '1;
      cs_sync_q   <= '1;
      sdi_sync_q  <= '0;
      sclk_prev_q <= 1'b1;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
      sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign rx_byte  = {rx_q, sdi_s};
  assign addr_inc = mb_q ? addr_q + 6'd1 : addr_q;
  assign byte_end = sclk_rise && (bit_cnt_q == 3'd7);
  assign rd_addr  = (state_q == StCmd) ? rx_byte[5:0] : addr_inc;
  assign rd_data  = (rd_addr == 6'h00) ? DEVID_VAL : mem_q[rd_addr];
  assign ro_hit   = (addr_q == 6'h00) || ((addr_q >= 6'h32) && (addr_q <= 6'h37));
  assign busy     = (state_q != StIdle);
  assign sdo_oe   = busy;
  assign sdo      = sdo_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    mb_d      = mb_q;
    sdo_d     = sdo_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        sdo_d = 1'b1;
        if (cs_fall) begin
          state_d   = StCmd;
          bit_cnt_d = 3'd0;
        end
      end
      StCmd: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          rx_d      = rx_byte[6:0];
          if (byte_end) begin
            mb_d   = rx_byte[6];
            addr_d = rx_byte[5:0];
            if (rx_byte[7]) begin
              state_d = StRd;
              tx_d    = rd_data;
            end else begin
              state_d = StWr;
            end
          end
        end
      end
      StRd: begin
        if (sclk_fall) begin
          sdo_d = tx_q[7];
          tx_d  = {tx_q[6:0], 1'b0};
        end
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (byte_end) begin
            addr_d = addr_inc;
            tx_d   = rd_data;
          end
        end
      end
      StWr: begin
        if (sclk_rise) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          rx_d      = rx_byte[6:0];
          if (byte_end) begin
            mem_we = ~ro_hit;
            addr_d = addr_inc;
          end
        end
      end
    endcase
    // CS release overrides everything, dropping any byte completing in the same clk
    if (cs_rise) begin
      state_d = StIdle;
      sdo_d   = 1'b1;
      mem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bit_cnt_q <= 3'd0;
      rx_q      <= 7'd0;
      tx_q      <= 8'd0;
      addr_q    <= 6'd0;
      mb_q      <= 1'b0;
      sdo_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      mb_q      <= mb_d;
      sdo_q     <= sdo_d;
    end
  end

  // Direct sample beats a pending one when both are available while idle
  assign ld_x = sample_valid ? axis_x : pend_x_q;
  assign ld_y = sample_valid ? axis_y : pend_y_q;
  assign ld_z = sample_valid ? axis_z : pend_z_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem_q[i] <= (i == 'h2C) ? BW_RATE_RST : 8'h00;
    end else begin
      if (mem_we) mem_q[addr_q] <= rx_byte;
      if (!busy && (sample_valid || pend_q)) begin
        mem_q[6'h32] <= ld_x[7:0];
        mem_q[6'h33] <= ld_x[15:8];
        mem_q[6'h34] <= ld_y[7:0];
        mem_q[6'h35] <= ld_y[15:8];
        mem_q[6'h36] <= ld_z[7:0];
        mem_q[6'h37] <= ld_z[15:8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      pend_x_q <= 16'd0;
      pend_y_q <= 16'd0;
      pend_z_q <= 16'd0;
    end else if (busy && sample_valid) begin
      pend_q   <= 1'b1;
      pend_x_q <= axis_x;
      pend_y_q <= axis_y;
      pend_z_q <= axis_z;
    end else if (!busy) begin
      pend_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_q      <= 1'b0;
      wr_addr_q     <= 6'd0;
      wr_data_q     <= 8'd0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= 6'd0;
      reg_wr_data   <= 8'd0;
    end else begin
      wr_req_q      <= mem_we;
      reg_wr_strobe <= wr_req_q;
      if (mem_we) begin
        wr_addr_q <= addr_q;
        wr_data_q <= rx_byte;
      end
      if (wr_req_q) begin
        reg_wr_addr <= wr_addr_q;
        reg_wr_data <= wr_data_q;
      end
    end
  end

`ifdef SPI_ACCEL_SLAVE_TXN_CNT_EN
  logic byte_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_done_q <= 1'b0;
      txn_count   <= 16'd0;
      cmd_err     <= 1'b0;
    end else begin
      if (cs_rise) begin
        if (busy && byte_done_q) txn_count <= txn_count + 16'd1;
        byte_done_q <= 1'b0;
      end else if (byte_end && (state_q == StRd || state_q == StWr)) begin
        byte_done_q <= 1'b1;
        if (state_q == StWr && ro_hit) cmd_err <= 1'b1;
      end
    end
  end
`endif

endmodule
